// File: rtl/axi_frame_writer.sv
// axi_frame_writer: AXI4 write master draining a FWFT pixel FIFO into ping-pong frame buffers
module axi_frame_writer #(
    parameter logic [31:0] BASE_ADDR0  = 32'h0000_0000,
    parameter logic [31:0] BASE_ADDR1  = 32'h0020_0000,
    parameter int          FRAME_WORDS = 307200,
    parameter int          BURST_LEN   = 64,
    parameter logic [3:0]  AXI_ID      = 4'd0,
    parameter int          LEVEL_W     = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_start_i,
    input  logic [LEVEL_W-1:0] fifo_level_i,
    input  logic [31:0]        fifo_data_i,
    output logic               fifo_rd_o,
    output logic               inport_awvalid_o,
    input  logic               inport_awready_i,
    output logic [31:0]        inport_awaddr_o,
    output logic [3:0]         inport_awid_o,
    output logic [7:0]         inport_awlen_o,
    output logic [1:0]         inport_awburst_o,
    output logic               inport_wvalid_o,
    input  logic               inport_wready_i,
    output logic [31:0]        inport_wdata_o,
    output logic [3:0]         inport_wstrb_o,
    output logic               inport_wlast_o,
    input  logic               inport_bvalid_i,
    output logic               inport_bready_o,
    input  logic [1:0]         inport_bresp_i,
    input  logic [3:0]         inport_bid_i,
    output logic               buf_sel_o,
    output logic               frame_done_o,
    output logic               err_o
);
    localparam int          CNT_W = $clog2(FRAME_WORDS + 1);
    localparam logic [31:0] BL    = 32'(BURST_LEN);
    localparam logic [31:0] FW    = 32'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t             state_q, state_d;
    logic               armed_q, armed_d, pend_q, pend_d;
    logic               wr_buf_q, wr_buf_d, buf_sel_q, buf_sel_d;
    logic               done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic [31:0]        awaddr_q, awaddr_d, next_words;
    logic               last_beat;
    logic               unused_bid;

    assign unused_bid       = ^inport_bid_i;
    assign last_beat        = beat_cnt_q == 8'(BURST_LEN - 1);
    assign next_words       = 32'(word_cnt_q) + BL;
    assign inport_awvalid_o = state_q == AW;
    assign inport_awaddr_o  = awaddr_q;
    assign inport_awid_o    = AXI_ID;
    assign inport_awlen_o   = 8'(BURST_LEN - 1);
    assign inport_awburst_o = 2'b01;
    assign inport_wvalid_o  = state_q == W;
    assign inport_wdata_o   = fifo_data_i;
    assign inport_wstrb_o   = 4'hF;
    assign inport_wlast_o   = (state_q == W) && last_beat;
    assign inport_bready_o  = state_q == B;
    assign fifo_rd_o        = inport_wvalid_o && inport_wready_i;
    assign buf_sel_o        = buf_sel_q;
    assign frame_done_o     = done_q;
    assign err_o            = err_q;

    // Burst sequencing, frame accounting and deferred frame-start handling
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        pend_d     = pend_q;
        wr_buf_d   = wr_buf_q;
        buf_sel_d  = buf_sel_q;
        done_d     = 1'b0;
        err_d      = err_q;
        word_cnt_d = word_cnt_q;
        beat_cnt_d = beat_cnt_q;
        awaddr_d   = awaddr_q;
        if (state_q != IDLE && frame_start_i) pend_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    word_cnt_d = '0;
                    armed_d    = 1'b1;
                end
                if (armed_q && 32'(fifo_level_i) >= BL) begin
                    state_d  = AW;
                    awaddr_d = (wr_buf_q ? BASE_ADDR1 : BASE_ADDR0) + (32'(word_cnt_d) << 2);
                end
            end
            AW: state_d = inport_awready_i ? W : AW;
            W: begin
                if (inport_wready_i) begin
                    beat_cnt_d = last_beat ? 8'd0 : beat_cnt_q + 8'd1;
                    state_d    = last_beat ? B : W;
                end
            end
            B: begin
                if (inport_bvalid_i) begin
                    err_d      = err_q | (inport_bresp_i != 2'b00);
                    word_cnt_d = CNT_W'(next_words);
                    if (next_words == FW) begin
                        done_d     = 1'b1;
                        buf_sel_d  = wr_buf_q;
                        wr_buf_d   = ~wr_buf_q;
                        word_cnt_d = '0;
                        armed_d    = 1'b0;
                    end
                    if (pend_d) begin
                        word_cnt_d = '0;
                        armed_d    = 1'b1;
                        pend_d     = 1'b0;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            pend_q     <= 1'b0;
            wr_buf_q   <= 1'b0;
            buf_sel_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            beat_cnt_q <= '0;
            awaddr_q   <= BASE_ADDR0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            pend_q     <= pend_d;
            wr_buf_q   <= wr_buf_d;
            buf_sel_q  <= buf_sel_d;
            done_q     <= done_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            awaddr_q   <= awaddr_d;
        end
    end
endmodule

// File: tb/tb_axi_frame_writer.sv
// tb_axi_frame_writer: directed checks of the ping-pong AXI frame writer with a two-burst frame
module tb_axi_frame_writer;
    localparam int          BL = 64;
    localparam logic [31:0] B1 = 32'h0020_0000;
    localparam logic [31:0] D0 = 32'hD000_0000;

    logic        clk_i = 1'b0, rst_i = 1'b1, frame_start_i = 1'b0;
    logic [10:0] fifo_level_i = '0;
    logic [31:0] fifo_data_i = D0;
    logic        fifo_rd_o, inport_awvalid_o, inport_awready_i = 1'b0;
    logic [31:0] inport_awaddr_o, inport_wdata_o;
    logic [3:0]  inport_awid_o, inport_wstrb_o, inport_bid_i = 4'h5;
    logic [7:0]  inport_awlen_o;
    logic [1:0]  inport_awburst_o, inport_bresp_i = 2'b00;
    logic        inport_wvalid_o, inport_wready_i = 1'b0, inport_wlast_o;
    logic        inport_bvalid_i = 1'b0, inport_bready_o;
    logic        buf_sel_o, frame_done_o, err_o;
    int          n_chk = 0, n_fail = 0, pops = 0, widx = 0;

    axi_frame_writer #(.FRAME_WORDS(128), .BURST_LEN(BL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .frame_start_i(frame_start_i),
        .fifo_level_i(fifo_level_i), .fifo_data_i(fifo_data_i), .fifo_rd_o(fifo_rd_o),
        .inport_awvalid_o(inport_awvalid_o), .inport_awready_i(inport_awready_i),
        .inport_awaddr_o(inport_awaddr_o), .inport_awid_o(inport_awid_o),
        .inport_awlen_o(inport_awlen_o), .inport_awburst_o(inport_awburst_o),
        .inport_wvalid_o(inport_wvalid_o), .inport_wready_i(inport_wready_i),
        .inport_wdata_o(inport_wdata_o), .inport_wstrb_o(inport_wstrb_o),
        .inport_wlast_o(inport_wlast_o), .inport_bvalid_i(inport_bvalid_i),
        .inport_bready_o(inport_bready_o), .inport_bresp_i(inport_bresp_i),
        .inport_bid_i(inport_bid_i), .buf_sel_o(buf_sel_o),
        .frame_done_o(frame_done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        frame_start_i = 1'b1;
        @(negedge clk_i);
        frame_start_i = 1'b0;
        #1;
    endtask

    task automatic quiet(input string tag, input int ncyc);
        int cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk_i);
            #1;
            if (inport_awvalid_o) cnt++;
        end
        check(tag, cnt, 0);
    endtask

    task automatic do_burst(input string nm, input logic [31:0] addr, input int aw_dly,
                            input bit wtog, input logic [1:0] resp, input int fs_beat,
                            input logic exp_fd, input logic exp_sel);
        int n = 0, beats = 0, rds = 0, lasts = 0, bad = 0, stable = 1;
        bit popped;
        while (!inport_awvalid_o && n < 300) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check({nm, "_aw_seen"}, inport_awvalid_o, 1);
        check({nm, "_awaddr"}, inport_awaddr_o, addr);
        check({nm, "_awlen"}, inport_awlen_o, BL - 1);
        check({nm, "_awburst_id"}, {inport_awburst_o, inport_awid_o}, 6'b01_0000);
        for (int i = 0; i < aw_dly; i++) begin
            if (!(inport_awvalid_o && inport_awaddr_o == addr && !inport_wvalid_o)) stable = 0;
            @(negedge clk_i);
            #1;
        end
        check({nm, "_aw_stable"}, stable, 1);
        inport_awready_i = 1'b1;
        @(negedge clk_i);
        inport_awready_i = 1'b0;
        for (int c = 0; c < 400 && beats < BL; c++) begin
            inport_wready_i = wtog ? (c % 2 == 0) : 1'b1;
            frame_start_i   = (beats == fs_beat);
            #1;
            popped = 0;
            if (inport_wvalid_o && inport_wready_i) begin
                if (inport_wdata_o !== D0 + 32'(widx) || inport_wstrb_o !== 4'hF) bad++;
                widx++;
                beats++;
                if (inport_wlast_o) begin
                    lasts++;
                    if (beats != BL) bad++;
                end
            end
            if (fifo_rd_o) begin
                rds++;
                popped = 1;
            end
            @(negedge clk_i);
            frame_start_i = 1'b0;
            if (popped) begin
                pops++;
                fifo_data_i = D0 + 32'(pops);
            end
        end
        inport_wready_i = 1'b0;
        #1;
        check({nm, "_beats"}, beats, BL);
        check({nm, "_fifo_rd"}, rds, BL);
        check({nm, "_wlast_cnt"}, lasts, 1);
        check({nm, "_data_errs"}, bad, 0);
        check({nm, "_b_state"}, {inport_wvalid_o, inport_bready_o}, 2'b01);
        @(negedge clk_i);
        inport_bvalid_i = 1'b1;
        inport_bresp_i  = resp;
        #1;
        check({nm, "_bready"}, inport_bready_o, 1);
        @(negedge clk_i);
        inport_bvalid_i = 1'b0;
        inport_bresp_i  = 2'b00;
        #1;
        check({nm, "_frame_done"}, frame_done_o, exp_fd);
        if (exp_fd) check({nm, "_buf_sel"}, buf_sel_o, exp_sel);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_ctrl", {inport_awvalid_o, inport_wvalid_o, inport_wlast_o, inport_bready_o, fifo_rd_o}, 0);
        check("rst_status", {frame_done_o, err_o, buf_sel_o}, 0);
        check("rst_awaddr", inport_awaddr_o, 32'h0);
        fifo_level_i = 11'd200;
        quiet("unarmed_idle", 1000);
        fifo_level_i = 11'd64;
        pulse_start();
        do_burst("f1b1", 32'h0, 0, 0, 2'b00, -1, 0, 0);
        do_burst("f1b2", 32'h100, 0, 0, 2'b00, -1, 1, 0);
        quiet("after_f1", 50);
        pulse_start();
        do_burst("f2b1", B1, 5, 1, 2'b00, -1, 0, 0);
        check("err_clear", err_o, 0);
        do_burst("f2b2", B1 + 32'h100, 0, 1, 2'b10, -1, 1, 1);
        check("err_set", err_o, 1);
        quiet("after_f2", 30);
        check("err_sticky", err_o, 1);
        pulse_start();
        do_burst("rs_b1", 32'h0, 0, 0, 2'b00, 30, 0, 0);
        do_burst("rs_b2", 32'h0, 0, 0, 2'b00, -1, 0, 0);
        do_burst("rs_b3", 32'h100, 0, 0, 2'b00, 30, 1, 0);
        do_burst("rs_b4", B1, 0, 0, 2'b00, -1, 0, 0);
        check("err_sticky2", err_o, 1);
        n = 0;
        while (!inport_awvalid_o && n < 100) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check("rst_aw_seen", inport_awvalid_o, 1);
        check("rst_awaddr_pre", inport_awaddr_o, B1 + 32'h100);
        inport_awready_i = 1'b1;
        @(negedge clk_i);
        inport_awready_i = 1'b0;
        inport_wready_i  = 1'b1;
        repeat (3) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_ctrl", {inport_awvalid_o, inport_wvalid_o, inport_wlast_o, inport_bready_o, fifo_rd_o}, 0);
        check("async_rst_status", {frame_done_o, err_o, buf_sel_o}, 0);
        check("async_rst_awaddr", inport_awaddr_o, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
